// File: rtl/glacier_spawner_if.sv
// Control/status bundle between the game sequencer and the glacier spawner.
// The sequencer drives frame sync and control; the spawner returns slot state and event pulses.
interface glacier_spawner_if #(
  parameter int NUM_SLOTS = 4
);
  logic                     i_v_sync;
  logic                     i_enable;
  logic                     i_clear;
  logic [NUM_SLOTS-1:0]     o_active;
  logic [NUM_SLOTS*16-1:0]  o_pos_x;
  logic [NUM_SLOTS*16-1:0]  o_pos_y;
  logic                     o_busy;
  logic                     o_update_done;
  logic                     o_spawn;
  logic                     o_overflow;
  logic                     o_tick_dropped;

  modport master (
    output i_v_sync, i_enable, i_clear,
    input  o_active, o_pos_x, o_pos_y, o_busy,
    input  o_update_done, o_spawn, o_overflow, o_tick_dropped
  );

  modport slave (
    input  i_v_sync, i_enable, i_clear,
    output o_active, o_pos_x, o_pos_y, o_busy,
    output o_update_done, o_spawn, o_overflow, o_tick_dropped
  );
endinterface

// File: rtl/glacier_spawner.sv
// Glacier sprite slot manager: each frame tick walks every slot (drift down-left,
// retire past the bottom limit), then periodically loads a free slot at a random x.
module glacier_spawner #(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_PERIOD = 90,
  parameter logic [15:0] X_MIN        = 16'd150,
  parameter logic [15:0] Y_START      = 16'd96,
  parameter logic [15:0] Y_LIMIT      = 16'd500
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  glacier_spawner_if.slave bus
);
  localparam int               IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int               CNT_W     = $clog2(SPAWN_PERIOD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_SPAWN} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [NUM_SLOTS-1:0]   active;
  logic [15:0]            pos_x [NUM_SLOTS];
  logic [15:0]            pos_y [NUM_SLOTS];
  logic [CNT_W-1:0]       frame_cnt;
  logic [15:0]            lfsr;
  logic                   vs_prev;
  logic                   busy, update_done, spawn, overflow, tick_dropped;

  logic                   tick;
  logic                   lfsr_fb;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [NUM_SLOTS*16-1:0] pos_x_flat, pos_y_flat;

  assign tick    = bus.i_v_sync & ~vs_prev;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (bus.i_enable) state_next = S_WAIT;
      S_WAIT: begin
        if (!bus.i_enable) state_next = S_IDLE;
        else if (tick)     state_next = S_UPDATE;
      end
      S_UPDATE: if (idx == LAST_IDX) state_next = S_SPAWN;
      S_SPAWN:  state_next = bus.i_enable ? S_WAIT : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (bus.i_clear) state_next = S_IDLE;
  end

  // Lowest-index free slot; the descending scan leaves the smallest index last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      pos_x_flat[16*k +: 16] = pos_x[k];
      pos_y_flat[16*k +: 16] = pos_y[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      active       <= '0;
      // NOTE: the slot arrays are reset explicitly because the visible positions must read zero after reset, not power-up garbage.
      for (int k = 0; k < NUM_SLOTS; k++) begin
        pos_x[k] <= '0;
        pos_y[k] <= '0;
      end
      frame_cnt    <= '0;
      lfsr         <= LFSR_SEED;
      vs_prev      <= 1'b0;
      busy         <= 1'b0;
      update_done  <= 1'b0;
      spawn        <= 1'b0;
      overflow     <= 1'b0;
      tick_dropped <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      vs_prev      <= bus.i_v_sync;
      state        <= state_next;
      busy         <= (state_next == S_UPDATE) || (state_next == S_SPAWN);
      update_done  <= 1'b0;
      spawn        <= 1'b0;
      overflow     <= 1'b0;
      tick_dropped <= 1'b0;

      if (bus.i_clear) begin
        active    <= '0;
        idx       <= '0;
        frame_cnt <= '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          pos_x[k] <= '0;
          pos_y[k] <= '0;
        end
      end else begin
        unique case (state)
          S_WAIT: idx <= '0;
          S_UPDATE: begin
            tick_dropped <= tick;
            if (active[idx]) begin
              if (pos_y[idx] > Y_LIMIT) begin
                active[idx] <= 1'b0;
              end else begin
                pos_y[idx] <= pos_y[idx] + 16'd1;
                pos_x[idx] <= pos_x[idx] - 16'd1;
              end
            end
            idx <= idx + 1'b1;
          end
          S_SPAWN: begin
            tick_dropped <= tick;
            update_done  <= 1'b1;
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              if (free_found) begin
                active[free_idx] <= 1'b1;
                pos_x[free_idx]  <= X_MIN + {8'd0, lfsr[7:0]};
                pos_y[free_idx]  <= Y_START;
                spawn            <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_active       = active;
  assign bus.o_pos_x        = pos_x_flat;
  assign bus.o_pos_y        = pos_y_flat;
  assign bus.o_busy         = busy;
  assign bus.o_update_done  = update_done;
  assign bus.o_spawn        = spawn;
  assign bus.o_overflow     = overflow;
  assign bus.o_tick_dropped = tick_dropped;
endmodule

// File: tb/tb_glacier_spawner.sv
// Randomized bench for glacier_spawner: a frame-level slot model predicts each pass,
// a monitor compares the DUT state whenever a pass completes.
module tb_glacier_spawner;
  localparam int N       = 4;
  localparam int PERIOD  = 90;
  localparam int X_MIN   = 150;
  localparam int Y_START = 96;
  localparam int Y_LIMIT = 500;

  typedef struct packed {
    logic [N-1:0]       active;
    logic [N-1:0][15:0] x;
    logic [N-1:0][15:0] y;
    int                 spawn_idx;
    bit                 overflow;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  glacier_spawner_if #(.NUM_SLOTS(N)) bus ();

  glacier_spawner #(
    .NUM_SLOTS   (N),
    .SPAWN_PERIOD(PERIOD),
    .X_MIN       (16'(X_MIN)),
    .Y_START     (16'(Y_START)),
    .Y_LIMIT     (16'(Y_LIMIT))
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int frames_done  = 0;
  int done_pulses  = 0;
  int dropped_seen = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  // Frame-level reference state
  bit          m_act [N];
  logic [15:0] m_x   [N];
  logic [15:0] m_y   [N];
  int          m_cnt;

  logic [15:0] m_lfsr, m_lfsr_prev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Free-running random source as the design sees it: seeded by reset, one step per clock.
  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst_n ? lfsr_step(m_lfsr) : 16'hACE1;
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = '0;
      m_y[i]   = '0;
    end
    m_cnt = 0;
  endtask

  // One whole frame: drift/retire every slot, then count toward the next spawn attempt.
  task automatic model_frame(output exp_t e);
    int j;
    e.spawn_idx = -1;
    e.overflow  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (m_y[i] > Y_LIMIT) m_act[i] = 1'b0;
        else begin
          m_y[i] = m_y[i] + 16'd1;
          m_x[i] = m_x[i] - 16'd1;
        end
      end
    end
    m_cnt++;
    if (m_cnt == PERIOD) begin
      m_cnt = 0;
      j = -1;
      for (int i = 0; i < N; i++) if (!m_act[i] && j < 0) j = i;
      if (j >= 0) begin
        m_act[j] = 1'b1;
        m_y[j]   = 16'(Y_START);
        e.spawn_idx = j;
      end else begin
        e.overflow = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      e.active[i] = m_act[i];
      e.x[i]      = m_x[i];
      e.y[i]      = m_y[i];
    end
  endtask

  // Monitor: compares slot state and event pulses whenever a pass completes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_tick_dropped) dropped_seen++;
      if (bus.o_update_done) begin
        done_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_update_done", bus.o_update_done, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.spawn_idx >= 0) begin
            mon_e.x[mon_e.spawn_idx] = 16'(X_MIN) + {8'd0, m_lfsr_prev[7:0]};
            m_x[mon_e.spawn_idx]     = mon_e.x[mon_e.spawn_idx];
          end
          check("active", bus.o_active, mon_e.active);
          check("pos_x", bus.o_pos_x, mon_e.x);
          check("pos_y", bus.o_pos_y, mon_e.y);
          check("spawn_pulse", bus.o_spawn, mon_e.spawn_idx >= 0);
          check("overflow_pulse", bus.o_overflow, mon_e.overflow);
          frames_done++;
        end
      end else if (bus.o_spawn || bus.o_overflow) begin
        check("stray_spawn_event", {bus.o_spawn, bus.o_overflow}, 2'b00);
      end
    end
  end

  task automatic wait_done(input int target);
    for (int c = 0; c < 60 && frames_done < target; c++) @(negedge clk);
    check("frame_done_timeout", frames_done >= target, 1'b1);
  endtask

  task automatic wait_busy();
    bit ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.o_busy;
    end
    check("busy_timeout", ok, 1'b1);
  endtask

  task automatic run_frame();
    exp_t e;
    int target;
    if ($urandom_range(0, 15) == 0) begin
      bus.i_enable = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      bus.i_enable = 1'b1;
      repeat (2) @(negedge clk);
    end
    model_frame(e);
    exp_q.push_back(e);
    target = frames_done + 1;
    bus.i_v_sync = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    wait_done(target);
    bus.i_v_sync = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Second rising edge of v_sync while the pass is running must be dropped, not queued.
  task automatic dropped_tick_frame();
    exp_t e;
    int target, d0;
    model_frame(e);
    exp_q.push_back(e);
    target = frames_done + 1;
    d0 = dropped_seen;
    bus.i_v_sync = 1'b1;
    wait_busy();
    bus.i_v_sync = 1'b0;
    @(negedge clk);
    bus.i_v_sync = 1'b1;
    wait_done(target);
    bus.i_v_sync = 1'b0;
    repeat (12) @(negedge clk);
    check("tick_dropped_count", dropped_seen, d0 + 1);
    check("single_pass_applied", frames_done, target);
  endtask

  // Dropping enable mid-pass finishes the pass, then parks in IDLE ignoring ticks.
  task automatic enable_drop_frame();
    exp_t e;
    int target;
    bit saw_busy = 1'b0;
    model_frame(e);
    exp_q.push_back(e);
    target = frames_done + 1;
    bus.i_v_sync = 1'b1;
    wait_busy();
    bus.i_enable = 1'b0;
    wait_done(target);
    bus.i_v_sync = 1'b0;
    repeat (2) @(negedge clk);
    bus.i_v_sync = 1'b1;
    repeat (8) begin
      @(negedge clk);
      saw_busy |= bus.o_busy;
    end
    bus.i_v_sync = 1'b0;
    check("disabled_tick_busy", saw_busy, 1'b0);
    bus.i_enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    int d0;
    bus.i_v_sync = 1'b0;
    bus.i_enable = 1'b0;
    bus.i_clear  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_active", bus.o_active, '0);
    check("reset_pos_x", bus.o_pos_x, '0);
    check("reset_pos_y", bus.o_pos_y, '0);
    check("reset_busy", bus.o_busy, 1'b0);
    check("reset_pulses", {bus.o_update_done, bus.o_spawn, bus.o_overflow, bus.o_tick_dropped}, 4'b0);
    rst_n = 1'b1;

    // Ticks in IDLE are ignored silently.
    @(negedge clk);
    bus.i_v_sync = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw |= bus.o_busy;
      bus.i_v_sync = 1'b0;
    end
    check("idle_tick_busy", saw, 1'b0);
    check("idle_tick_dropped", dropped_seen, 0);

    bus.i_enable = 1'b1;
    repeat (2) @(negedge clk);

    // Spawns at frames 90..360, overflow at 450, slot 0 retires ~496 and respawns at 540.
    for (int f = 0; f < 560; f++) begin
      if (f == 200)      dropped_tick_frame();
      else if (f == 300) enable_drop_frame();
      else               run_frame();
    end

    // Clear while the pass is on slot 2.
    d0 = done_pulses;
    bus.i_v_sync = 1'b1;
    wait_busy();
    @(negedge clk);
    @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    check("clear_active", bus.o_active, '0);
    check("clear_pos_x", bus.o_pos_x, '0);
    check("clear_pos_y", bus.o_pos_y, '0);
    check("clear_busy", bus.o_busy, 1'b0);
    bus.i_clear  = 1'b0;
    bus.i_v_sync = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    check("clear_no_update_done", done_pulses, d0);

    for (int f = 0; f < 92; f++) run_frame();

    // Reset in the middle of a pass discards it entirely.
    d0 = done_pulses;
    bus.i_v_sync = 1'b1;
    wait_busy();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_active", bus.o_active, '0);
    check("midreset_pos_x", bus.o_pos_x, '0);
    check("midreset_busy", bus.o_busy, 1'b0);
    rst_n = 1'b1;
    bus.i_v_sync = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    check("midreset_no_update_done", done_pulses, d0);

    for (int f = 0; f < 91; f++) run_frame();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/glacier_spawner.md
GLACIER_SPAWNER -- requirements
Module: glacier_spawner

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of glacier sprite slots managed.
REQ-002 Parameter SPAWN_PERIOD, default 90: frames between spawn attempts (>=2).
REQ-003 Parameter X_MIN, default 16'd150: base x for spawned glaciers.
REQ-004 Parameter Y_START, default 16'd96: y for spawned glaciers.
REQ-005 Parameter Y_LIMIT, default 16'd500: slot retires when y > Y_LIMIT.
REQ-006 i_clk  in  1  sole clock; all logic on rising edge.
REQ-007 i_rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_v_sync  in  1  vertical sync, synchronous to i_clk; rising edge = frame tick.
REQ-009 i_enable  in  1  1 = game running, slots advance and spawn.
REQ-010 i_clear  in  1  synchronous clear of all slots (level, sampled each cycle).
REQ-011 o_active  out  NUM_SLOTS  per-slot active flag, bit k = slot k.
REQ-012 o_pos_x  out  NUM_SLOTS*16  slot k x at bits [16k+15:16k].
REQ-013 o_pos_y  out  NUM_SLOTS*16  slot k y, same packing.
REQ-014 o_busy  out  1  high while in UPDATE or SPAWN.
REQ-015 o_update_done  out  1  one-cycle pulse when a frame pass completes.
REQ-016 o_spawn  out  1  one-cycle pulse when a slot is loaded.
REQ-017 o_overflow  out  1  one-cycle pulse when spawn due but no free slot.
REQ-018 o_tick_dropped  out  1  one-cycle pulse when a tick arrives while busy.

Function
REQ-019 Tick detection: register i_v_sync once; tick = i_v_sync & ~prev; tick valid one cycle after the rising edge is sampled.
REQ-020 FSM states: IDLE, WAIT, UPDATE, SPAWN; all outputs registered.
REQ-021 IDLE: i_enable=1 -> WAIT; ticks ignored; o_tick_dropped never asserted.
REQ-022 WAIT: i_enable=0 -> IDLE; else tick -> UPDATE with slot index k=0.
REQ-023 UPDATE: one slot per cycle, k=0..NUM_SLOTS-1, NUM_SLOTS cycles total.
REQ-024 UPDATE slot k, active and y > Y_LIMIT: clear active; x,y hold.
REQ-025 UPDATE slot k, active and y <= Y_LIMIT: y <= y+1, x <= x-1, 16-bit modulo (x=0 wraps to 16'hFFFF).
REQ-026 UPDATE slot k inactive: unchanged.
REQ-027 After k=NUM_SLOTS-1 -> SPAWN (one cycle).
REQ-028 SPAWN: frame counter increments; if counter == SPAWN_PERIOD-1, counter <= 0 and spawn attempt, else no attempt.
REQ-029 Spawn attempt: lowest-index inactive slot j loaded x = X_MIN + {8'd0, lfsr[7:0]}, y = Y_START, active=1; o_spawn pulses.
REQ-030 Spawn attempt with all slots active: no slot change, o_overflow pulses, counter still resets to 0.
REQ-031 A slot retired in UPDATE of the same frame is free for that frame's spawn.
REQ-032 Leaving SPAWN: o_update_done pulses; next state WAIT if i_enable=1, else IDLE.
REQ-033 i_enable deasserted during UPDATE/SPAWN: current pass completes, then IDLE; positions retained.
REQ-034 Tick during UPDATE or SPAWN: discarded, o_tick_dropped pulses; not queued.
REQ-035 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, never all-zero.
REQ-036 i_clear=1 (any state): all active <= 0, x,y <= 0, counter <= 0, state <= IDLE, all pulses 0; LFSR unaffected; i_clear dominates tick and i_enable.
REQ-037 o_busy = 1 exactly in UPDATE and SPAWN.

Reset
REQ-038 i_rst_n=0 sampled at clock edge: state IDLE, o_active=0, o_pos_x=0, o_pos_y=0, counter 0, prev v_sync 0, LFSR 16'hACE1, all pulse outputs 0, o_busy 0.
REQ-039 Reset mid-UPDATE/SPAWN aborts the pass with no partial update surviving; reset dominates i_clear.

Verification
REQ-040 Reset, i_enable=1, 89 ticks -> no o_spawn; tick 90 -> o_spawn, slot 0 active, y=96, x=150+lfsr[7:0]; o_update_done once per tick.
REQ-041 Slot 0 at y=500, x=5, tick -> y=501, x=4; next tick -> active 0, x=4, y=501 retained.
REQ-042 Slot at x=0 active, tick -> x=16'hFFFF, y+1.
REQ-043 All 4 slots active, spawn due -> o_overflow one cycle, no slot change, counter restarts (next attempt 90 ticks later).
REQ-044 Second v_sync rising edge while o_busy=1 -> o_tick_dropped one cycle, exactly one pass applied.
REQ-045 i_clear=1 during UPDATE of slot 2 -> next cycle o_active=0, positions 0, IDLE, o_busy=0, no o_update_done.
